// File: rtl/mux_key_reg_pkg.sv
// mux_key_reg_pkg: shared sizing helper for the key-match lookup table.
//   pair_len(k, d): width of one packed (key, data) table entry.
package mux_key_reg_pkg;
   function automatic int pair_len(input int key_len, input int data_len);
      return key_len + data_len;
   endfunction
endpackage

// File: rtl/mux_key_core.sv
// mux_key_core: combinational key-match lookup over a packed (key, data) table.
//   key         - lookup key
//   default_out - result when no entry matches
//   lut         - packed table, entry i at lut[PAIR_LEN*i +: PAIR_LEN], key in upper bits
//   out         - OR of all matching data words, or default_out on a miss
//   hit         - at least one entry matched
module mux_key_core
   import mux_key_reg_pkg::*;
#(
   parameter int NR_KEY   = 6,
   parameter int KEY_LEN  = 3,
   parameter int DATA_LEN = 2
) (
   input  logic [KEY_LEN-1:0]                             key,
   input  logic [DATA_LEN-1:0]                            default_out,
   input  logic [NR_KEY*pair_len(KEY_LEN,DATA_LEN)-1:0]   lut,
   output logic [DATA_LEN-1:0]                            out,
   output logic                                           hit
);
   localparam int PAIR_LEN = pair_len(KEY_LEN, DATA_LEN);
   logic [NR_KEY-1:0]   match;
   logic [DATA_LEN-1:0] data_w [NR_KEY];
   logic [DATA_LEN-1:0] or_data;
   for (genvar g = 0; g < NR_KEY; g++) begin : g_entry
      assign match[g]  = key == lut[PAIR_LEN*g+DATA_LEN +: KEY_LEN];
      assign data_w[g] = lut[PAIR_LEN*g +: DATA_LEN];
   end
   // Duplicate keys are legal: every matching word contributes, no priority.
   always_comb begin
      or_data = '0;
      for (int i = 0; i < NR_KEY; i++) or_data = or_data | (match[i] ? data_w[i] : '0);
   end
   assign hit = |match;
   assign out = hit ? or_data : default_out;
endmodule

// File: rtl/mux_key_reg.sv
// mux_key_reg: key-match lookup with combinational result and enabled, async-reset registered copy.
//   clk, rst    - rising-edge clock, async active-high reset of out_q/hit_q only
//   en          - load enable for out_q/hit_q
//   key, default_out, lut, out, hit - see mux_key_core
//   out_q, hit_q - registered out/hit
module mux_key_reg
   import mux_key_reg_pkg::*;
#(
   parameter int NR_KEY   = 6,
   parameter int KEY_LEN  = 3,
   parameter int DATA_LEN = 2
) (
   input  logic                                           clk,
   input  logic                                           rst,
   input  logic                                           en,
   input  logic [KEY_LEN-1:0]                             key,
   input  logic [DATA_LEN-1:0]                            default_out,
   input  logic [NR_KEY*pair_len(KEY_LEN,DATA_LEN)-1:0]   lut,
   output logic [DATA_LEN-1:0]                            out,
   output logic                                           hit,
   output logic [DATA_LEN-1:0]                            out_q,
   output logic                                           hit_q
);
   logic [DATA_LEN-1:0] out_d;
   logic                hit_d;
   mux_key_core #(
      .NR_KEY   (NR_KEY),
      .KEY_LEN  (KEY_LEN),
      .DATA_LEN (DATA_LEN)
   ) u_core (
      .key         (key),
      .default_out (default_out),
      .lut         (lut),
      .out         (out),
      .hit         (hit)
   );
   assign out_d = en ? out : out_q;
   assign hit_d = en ? hit : hit_q;
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_q <= '0;
         hit_q <= 1'b0;
      end else begin
         out_q <= out_d;
         hit_q <= hit_d;
      end
   end
endmodule

// File: tb/tb_mux_key_reg.sv
// tb_mux_key_reg: directed self-checking bench for mux_key_reg.
module tb_mux_key_reg;
   logic        clk = 1'b0;
   logic        rst;
   logic        en;
   logic [2:0]  key;
   logic [1:0]  default_out;
   logic [29:0] lut;
   logic [1:0]  out;
   logic        hit;
   logic [1:0]  out_q;
   logic        hit_q;
   int          n_pass = 0;
   int          n_total = 0;
   logic [29:0] lut_base;
   logic [2:0]  ref_key  [6] = '{3'b111, 3'b110, 3'b101, 3'b100, 3'b001, 3'b000};
   logic [1:0]  ref_data [6] = '{2'b10,  2'b00,  2'b00,  2'b10,  2'b10,  2'b00};

   always #5 clk = ~clk;

   mux_key_reg #(.NR_KEY(6), .KEY_LEN(3), .DATA_LEN(2)) dut (
      .clk         (clk),
      .rst         (rst),
      .en          (en),
      .key         (key),
      .default_out (default_out),
      .lut         (lut),
      .out         (out),
      .hit         (hit),
      .out_q       (out_q),
      .hit_q       (hit_q)
   );

   task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
      n_total++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   initial begin
      lut_base = {3'b000, 2'b00, 3'b001, 2'b10, 3'b100, 2'b10,
                  3'b101, 2'b00, 3'b110, 2'b00, 3'b111, 2'b10};
      rst = 1'b1;
      en = 1'b0;
      key = 3'b000;
      default_out = 2'b00;
      lut = lut_base;
      #2;
      check("rst out_q", 8'(out_q), 8'h0);
      check("rst hit_q", 8'(hit_q), 8'h0);
      @(negedge clk);
      rst = 1'b0;
      key = 3'b001; #1;
      check("k001 out", 8'(out), 8'h2);
      check("k001 hit", 8'(hit), 8'h1);
      key = 3'b111; #1;
      check("k111 out", 8'(out), 8'h2);
      check("k111 hit", 8'(hit), 8'h1);
      key = 3'b101; #1;
      check("k101 out", 8'(out), 8'h0);
      check("k101 hit", 8'(hit), 8'h1);
      key = 3'b010; #1;
      check("miss out", 8'(out), 8'h0);
      check("miss hit", 8'(hit), 8'h0);
      default_out = 2'b11; #1;
      check("miss dflt11 out", 8'(out), 8'h3);
      check("miss dflt11 hit", 8'(hit), 8'h0);
      lut = {3'b011, 2'b01, 3'b001, 2'b10, 3'b100, 2'b10,
             3'b101, 2'b00, 3'b011, 2'b10, 3'b111, 2'b10};
      key = 3'b011; #1;
      check("dup out", 8'(out), 8'h3);
      check("dup hit", 8'(hit), 8'h1);
      lut = lut_base;
      default_out = 2'b00;
      en = 1'b1;
      key = 3'b001;
      @(posedge clk); #1;
      check("load out_q", 8'(out_q), 8'h2);
      check("load hit_q", 8'(hit_q), 8'h1);
      en = 1'b0;
      key = 3'b010;
      for (int c = 0; c < 3; c++) begin
         @(posedge clk); #1;
         check("hold out_q", 8'(out_q), 8'h2);
         check("hold hit_q", 8'(hit_q), 8'h1);
         check("hold out", 8'(out), 8'h0);
         check("hold hit", 8'(hit), 8'h0);
      end
      key = 3'b001;
      en = 1'b1;
      #2;
      rst = 1'b1;
      #1;
      check("async out_q", 8'(out_q), 8'h0);
      check("async hit_q", 8'(hit_q), 8'h0);
      check("rst comb out", 8'(out), 8'h2);
      @(posedge clk); #1;
      check("rst held out_q", 8'(out_q), 8'h0);
      check("rst held hit_q", 8'(hit_q), 8'h0);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk); #1;
      check("reload out_q", 8'(out_q), 8'h2);
      check("reload hit_q", 8'(hit_q), 8'h1);
      default_out = 2'b01;
      for (int k = 0; k < 8; k++) begin
         logic [1:0] exp_out;
         logic       exp_hit;
         exp_out = 2'b00;
         exp_hit = 1'b0;
         for (int i = 0; i < 6; i++)
            if (ref_key[i] == 3'(k)) begin
               exp_hit = 1'b1;
               exp_out = exp_out | ref_data[i];
            end
         if (!exp_hit) exp_out = default_out;
         key = 3'(k); #1;
         check($sformatf("sweep out k%0d", k), 8'(out), 8'(exp_out));
         check($sformatf("sweep hit k%0d", k), 8'(hit), 8'(exp_hit));
      end
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
